// File: rtl/parity_check_rx.sv
// Serial frame receiver: deserialises DATA_W data bits (MSB first) plus one parity bit,
// checks even/odd parity, and keeps a saturating count of frames that failed the check.
module parity_check_rx #(
    parameter int DATA_W  = 3,
    parameter bit ODD_PAR = 1'b0,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              frame_abort,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              par_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int                  CNT_BITS  = $clog2(DATA_W + 1);
    localparam logic [CNT_BITS-1:0] LAST_DATA = CNT_BITS'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   shift_next;
    logic [CNT_BITS-1:0] cnt_q;
    logic                xor_q;
    logic                total;
    logic                frame_bad;
    logic                frame_end;

    assign shift_next = (shift_q << 1) | DATA_W'(bit_in);
    assign total      = xor_q ^ bit_in;
    assign frame_bad  = total ^ ODD_PAR;
    assign frame_end  = (state == PAR) && bit_valid && !frame_abort;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaulting state_next before the case keeps this purely combinational (no latch).
    always_comb begin
        state_next = state;
        if (frame_abort) begin
            state_next = IDLE;
        end else if (bit_valid) begin
            case (state)
                IDLE:    state_next = (DATA_W == 1) ? PAR : DATA;
                DATA:    state_next = (cnt_q == LAST_DATA) ? PAR : DATA;
                PAR:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Abort clears only the in-flight frame; delivered results stay visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            xor_q      <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_abort) begin
                cnt_q <= '0;
                xor_q <= 1'b0;
            end else if (bit_valid) begin
                case (state)
                    IDLE: begin
                        shift_q <= shift_next;
                        xor_q   <= bit_in;
                        cnt_q   <= CNT_BITS'(1);
                    end
                    DATA: begin
                        shift_q <= shift_next;
                        xor_q   <= xor_q ^ bit_in;
                        cnt_q   <= cnt_q + CNT_BITS'(1);
                    end
                    PAR: begin
                        data_out   <= shift_q;
                        par_err    <= frame_bad;
                        frame_done <= 1'b1;
                        cnt_q      <= '0;
                        xor_q      <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt <= '0;
        end else if (frame_end && frame_bad && !(&err_cnt)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parity_check_rx.sv
// Self-checking bench for parity_check_rx: three instances (even/8-bit count, odd parity,
// even/2-bit count) share one stimulus stream and are compared against a frame-level model.
module tb_parity_check_rx;

    localparam int DATA_W = 3;

    logic clk = 1'b0;
    logic rst, bit_in, bit_valid, frame_abort, err_clr;

    logic [DATA_W-1:0] data_out_e, data_out_o, data_out_s;
    logic              frame_done_e, frame_done_o, frame_done_s;
    logic              par_err_e, par_err_o, par_err_s;
    logic [7:0]        err_cnt_e, err_cnt_o;
    logic [1:0]        err_cnt_s;
    logic              busy_e, busy_o, busy_s;

    int n_total = 0;
    int n_pass  = 0;

    // Frame-level reference model
    logic        q[$];
    logic [2:0]  exp_data;
    logic        exp_done, exp_par_even, exp_par_odd, exp_busy;
    logic [7:0]  exp_cnt_e, exp_cnt_o;
    logic [1:0]  exp_cnt_s;

    always #5 clk = ~clk;

    parity_check_rx #(.DATA_W(DATA_W), .ODD_PAR(1'b0), .CNT_W(8)) dut_e (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_abort(frame_abort), .err_clr(err_clr), .data_out(data_out_e),
        .frame_done(frame_done_e), .par_err(par_err_e), .err_cnt(err_cnt_e), .busy(busy_e)
    );

    parity_check_rx #(.DATA_W(DATA_W), .ODD_PAR(1'b1), .CNT_W(8)) dut_o (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_abort(frame_abort), .err_clr(err_clr), .data_out(data_out_o),
        .frame_done(frame_done_o), .par_err(par_err_o), .err_cnt(err_cnt_o), .busy(busy_o)
    );

    parity_check_rx #(.DATA_W(DATA_W), .ODD_PAR(1'b0), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_abort(frame_abort), .err_clr(err_clr), .data_out(data_out_s),
        .frame_done(frame_done_s), .par_err(par_err_s), .err_cnt(err_cnt_s), .busy(busy_s)
    );

    // A frame is the list of accepted bits; it completes when DATA_W+1 bits have arrived.
    task automatic model_step();
        int ones;
        if (rst) begin
            q.delete();
            exp_data = '0; exp_done = 0; exp_par_even = 0; exp_par_odd = 0;
            exp_cnt_e = 0; exp_cnt_o = 0; exp_cnt_s = 0;
        end else begin
            exp_done = 0;
            if (frame_abort) begin
                q.delete();
            end else if (bit_valid) begin
                q.push_back(bit_in);
                if (q.size() == DATA_W + 1) begin
                    ones = 0;
                    exp_data = '0;
                    for (int i = 0; i < DATA_W; i++) exp_data = {exp_data[1:0], q[i]};
                    for (int i = 0; i <= DATA_W; i++) ones += int'(q[i]);
                    exp_par_even = (ones % 2 == 1);
                    exp_par_odd  = (ones % 2 == 0);
                    exp_done = 1;
                    q.delete();
                    if (exp_par_even && exp_cnt_e < 255) exp_cnt_e++;
                    if (exp_par_odd  && exp_cnt_o < 255) exp_cnt_o++;
                    if (exp_par_even && exp_cnt_s < 3)   exp_cnt_s++;
                end
            end
            if (err_clr) begin
                exp_cnt_e = 0; exp_cnt_o = 0; exp_cnt_s = 0;
            end
        end
        exp_busy = (q.size() != 0);
    endtask

    task automatic drive(input logic v, input logic b, input logic ab, input logic clr, input logic r);
        bit_valid = v; bit_in = b; frame_abort = ab; err_clr = clr; rst = r;
        @(posedge clk);
        model_step();
        #1;
        bit_valid = 0; frame_abort = 0; err_clr = 0; rst = 0;
    endtask

    task automatic send_frame(input logic [2:0] d, input logic p, input int gap);
        for (int i = 2; i >= 0; i--) begin
            drive(1, d[i], 0, 0, 0);
            if (i > 0) repeat (gap) drive(0, 0, 0, 0, 0);
        end
        drive(1, p, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if ({data_out_e, frame_done_e, par_err_e, err_cnt_e, busy_e,
                 data_out_o, frame_done_o, par_err_o, err_cnt_o, busy_o,
                 data_out_s, frame_done_s, par_err_s, err_cnt_s, busy_s} !== '0)
                $display("FAIL reset_idle cyc %0d: data=%b done=%b perr=%b cnt=%0d busy=%b, want all 0",
                         i, data_out_e, frame_done_e, par_err_e, err_cnt_e, busy_e);
            else n_pass++;
            drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_even_pass();
        drive(1, 1, 0, 0, 0);
        n_total++;
        if (busy_e !== 1'b1) $display("FAIL busy_in_frame: got %b want 1", busy_e);
        else n_pass++;
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        n_total++;
        if (frame_done_e !== 1'b0) $display("FAIL early_done: got %b want 0", frame_done_e);
        else n_pass++;
        drive(1, 1, 0, 0, 0);
        n_total++;
        if ({frame_done_e, data_out_e, par_err_e, err_cnt_e} !== {1'b1, 3'b111, 1'b0, 8'd0})
            $display("FAIL even_pass: done=%b data=%b perr=%b cnt=%0d, want 1 111 0 0",
                     frame_done_e, data_out_e, par_err_e, err_cnt_e);
        else n_pass++;
        drive(0, 0, 0, 0, 0);
        n_total++;
        if ({frame_done_e, data_out_e, busy_e} !== {1'b0, 3'b111, 1'b0})
            $display("FAIL done_pulse_hold: done=%b data=%b busy=%b, want 0 111 0",
                     frame_done_e, data_out_e, busy_e);
        else n_pass++;
    endtask

    task automatic test_gaps_error();
        send_frame(3'b011, 1'b1, 2);
        n_total++;
        if ({frame_done_e, data_out_e, par_err_e, err_cnt_e} !== {1'b1, 3'b011, 1'b1, 8'd1})
            $display("FAIL gap_error: done=%b data=%b perr=%b cnt=%0d, want 1 011 1 1",
                     frame_done_e, data_out_e, par_err_e, err_cnt_e);
        else n_pass++;
        send_frame(3'b101, 1'b0, 0);
        n_total++;
        if ({frame_done_e, data_out_e, par_err_e, err_cnt_e} !== {1'b1, 3'b101, 1'b0, 8'd1})
            $display("FAIL back_to_back: done=%b data=%b perr=%b cnt=%0d, want 1 101 0 1",
                     frame_done_e, data_out_e, par_err_e, err_cnt_e);
        else n_pass++;
    endtask

    task automatic test_odd();
        send_frame(3'b001, 1'b0, 0);
        n_total++;
        if ({par_err_o, par_err_e, err_cnt_e} !== {1'b0, 1'b1, exp_cnt_e})
            $display("FAIL odd_good: odd_perr=%b even_perr=%b cnt=%0d, want 0 1 %0d",
                     par_err_o, par_err_e, err_cnt_e, exp_cnt_e);
        else n_pass++;
        send_frame(3'b001, 1'b1, 1);
        n_total++;
        if ({par_err_o, err_cnt_o, par_err_e} !== {1'b1, exp_cnt_o, 1'b0})
            $display("FAIL odd_bad: odd_perr=%b odd_cnt=%0d even_perr=%b, want 1 %0d 0",
                     par_err_o, err_cnt_o, par_err_e, exp_cnt_o);
        else n_pass++;
    endtask

    task automatic test_abort();
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        n_total++;
        if ({busy_e, frame_done_e, data_out_e} !== {1'b0, 1'b0, 3'b001})
            $display("FAIL abort: busy=%b done=%b data=%b, want 0 0 001",
                     busy_e, frame_done_e, data_out_e);
        else n_pass++;
        drive(0, 0, 0, 0, 0);
        n_total++;
        if ({busy_e, frame_done_e} !== 2'b00)
            $display("FAIL abort_quiet: busy=%b done=%b, want 0 0", busy_e, frame_done_e);
        else n_pass++;
        send_frame(3'b001, 1'b1, 0);
        n_total++;
        if ({frame_done_e, data_out_e, par_err_e} !== {1'b1, 3'b001, 1'b0})
            $display("FAIL after_abort: done=%b data=%b perr=%b, want 1 001 0",
                     frame_done_e, data_out_e, par_err_e);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) send_frame(3'b100, 1'b0, 0);
        n_total++;
        if ({err_cnt_s, err_cnt_e} !== {2'd3, exp_cnt_e})
            $display("FAIL saturate: cnt2=%0d cnt8=%0d, want 3 %0d", err_cnt_s, err_cnt_e, exp_cnt_e);
        else n_pass++;
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        n_total++;
        if ({err_cnt_s, par_err_s, err_cnt_e, frame_done_s} !== {2'd0, 1'b1, 8'd0, 1'b1})
            $display("FAIL clr_priority: cnt2=%0d perr=%b cnt8=%0d done=%b, want 0 1 0 1",
                     err_cnt_s, par_err_s, err_cnt_e, frame_done_s);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 1);
        n_total++;
        if ({data_out_e, frame_done_e, par_err_e, err_cnt_e, busy_e,
             data_out_s, par_err_s, err_cnt_s, busy_s} !== '0)
            $display("FAIL mid_reset: data=%b perr=%b cnt=%0d busy=%b, want all 0",
                     data_out_e, par_err_e, err_cnt_e, busy_e);
        else n_pass++;
        send_frame(3'b110, 1'b0, 1);
        n_total++;
        if ({frame_done_e, data_out_e, par_err_e, par_err_o} !== {1'b1, 3'b110, 1'b0, 1'b1})
            $display("FAIL post_reset_frame: done=%b data=%b perr=%b odd_perr=%b, want 1 110 0 1",
                     frame_done_e, data_out_e, par_err_e, par_err_o);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(99) < 70), 1'($urandom), ($urandom_range(99) < 3),
                  ($urandom_range(99) < 3), ($urandom_range(299) == 0));
            n_total++;
            if ({data_out_e, frame_done_e, par_err_e, err_cnt_e, busy_e,
                 data_out_o, frame_done_o, par_err_o, err_cnt_o, busy_o,
                 data_out_s, frame_done_s, par_err_s, err_cnt_s, busy_s} !==
                {exp_data, exp_done, exp_par_even, exp_cnt_e, exp_busy,
                 exp_data, exp_done, exp_par_odd, exp_cnt_o, exp_busy,
                 exp_data, exp_done, exp_par_even, exp_cnt_s, exp_busy})
                $display("FAIL random cyc %0d: e=%b/%b/%b/%0d/%b o=%b/%0d s=%0d, want %b/%b/%b/%0d/%b o=%b/%0d s=%0d",
                         i, data_out_e, frame_done_e, par_err_e, err_cnt_e, busy_e,
                         par_err_o, err_cnt_o, err_cnt_s,
                         exp_data, exp_done, exp_par_even, exp_cnt_e, exp_busy,
                         exp_par_odd, exp_cnt_o, exp_cnt_s);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1; bit_in = 0; bit_valid = 0; frame_abort = 0; err_clr = 0;
        test_reset();
        test_even_pass();
        test_gaps_error();
        test_odd();
        test_abort();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/parity_check_rx.md
Name: parity_check_rx

Overview:
- Receive-side counterpart of the team's parity generator.
- Deserialises a frame of DATA_W data bits (MSB first) followed by one parity bit from a bit-serial, valid-qualified input.
- Checks parity (even or odd), presents the parallel word with an error flag, and keeps a saturating parity-error count.
- Sits between a serial link front end and the parallel datapath.

Parameters:
- DATA_W, 3: data bits per frame; legal range 1..32.
- ODD_PAR, 0: 0 = even parity checked, 1 = odd parity checked.
- CNT_W, 8: width of the error counter.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial frame bit.
- bit_valid  input  1  bit_in is consumed on a rising edge when high.
- frame_abort  input  1  discards the partial frame and returns to IDLE.
- err_clr  input  1  clears err_cnt.
- data_out  output  DATA_W  last received data word.
- frame_done  output  1  one-cycle pulse when a frame completes.
- par_err  output  1  parity result of the last frame (1 = mismatch).
- err_cnt  output  CNT_W  count of frames with par_err = 1; saturating.
- busy  output  1  high while a frame is partially received.

Behaviour:
- Reset (clk edge with rst = 1): state = IDLE; shift register, running XOR and bit counter = 0; data_out = 0, frame_done = 0, par_err = 0, err_cnt = 0, busy = 0. rst overrides every other input.
- State IDLE:
  - bit_valid = 1: shift in bit_in, xor = bit_in, cnt = 1, go to DATA. If DATA_W = 1, go straight to PAR.
- State DATA:
  - Each bit_valid: shift left with bit_in entering the LSB, xor ^= bit_in, cnt++.
  - When the accepted bit is the DATA_W-th bit, go to PAR.
  - bit_valid = 0: hold everything; gaps of any length are allowed.
- State PAR:
  - On the first bit_valid: total = xor ^ bit_in.
  - par_err <= total for even parity (ODD_PAR = 0), or ~total for odd parity (ODD_PAR = 1).
  - data_out <= shift register; frame_done <= 1 for that single following cycle; go to IDLE.
- Latency: frame_done, data_out and par_err update on the edge that accepts the parity bit and are visible the cycle after.
- data_out and par_err hold until the next frame completes. frame_done is 0 at all other times.
- Back-to-back frames: a bit_valid in IDLE during the frame_done cycle starts the next frame normally, so there are no dead cycles.
- busy = 1 in DATA and PAR, 0 in IDLE.
- frame_abort = 1:
  - Next state is IDLE, cnt and xor are cleared, and the bit on bit_in that cycle is dropped.
  - data_out, par_err and err_cnt are unchanged, and frame_done does not pulse.
  - Abort has priority over bit_valid in every state.
- err_cnt:
  - Increments on frame completion with a mismatch and saturates at all-ones (no wrap).
  - err_clr = 1 forces 0, with priority over a simultaneous increment; par_err still reports that frame.
- Widths: the bit counter is clog2(DATA_W + 1) bits. All XOR is single-bit.

Test Plan:
- Reset then idle: hold rst for 2 cycles with bit_valid = 0 → all outputs 0 and busy = 0 for 10 cycles.
- Even-parity pass (DATA_W = 3, ODD_PAR = 0): send 1,1,1 then parity 1 on consecutive cycles → next cycle frame_done = 1, data_out = 3'b111, par_err = 0, err_cnt = 0.
- Error, gaps and counting: send 0,1,1 with 2-cycle bit_valid gaps, then parity 1 → data_out = 3'b011, par_err = 1, err_cnt = 1. Then send 1,0,1 with parity 0 back-to-back with no idle cycle → par_err = 0, err_cnt stays 1.
- Odd-parity build (ODD_PAR = 1): send 0,0,1 then parity 0 → par_err = 0. Send 0,0,1 then parity 1 → par_err = 1.
- Abort: send 1,0 then assert frame_abort → busy = 0, no frame_done, data_out unchanged. Then send 0,0,1 plus parity 1 → data_out = 3'b001, par_err = 0.
- Saturation and clear (CNT_W = 2): send 5 bad frames → err_cnt = 3. Assert err_clr in the same cycle as a bad parity bit → err_cnt = 0 and par_err = 1.
- Mid-frame reset: assert rst after 2 data bits → everything 0. A following full frame decodes correctly.
